// File: rtl/weighted_sum_pkg.sv
// Shared definitions for the weighted_sum block.
//   - FSM state encodings (IDLE=0, ACCUM=1, CONVERT=2)
//   - ceiling log2 and max helpers usable in constant expressions
//   - accumulator width derivation
// Optional feature macro: WEIGHTED_SUM_BIAS_EN (adds one accumulator bit for the bias term).
package weighted_sum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_CONVERT = 2'd2
    } state_t;

`ifdef WEIGHTED_SUM_BIAS_EN
    localparam int BIAS_BITS = 1;
`else
    localparam int BIAS_BITS = 0;
`endif

    // Ceiling log2; log2(1) = 0.
    function automatic int log2(input int value);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Wide enough that INPUT_NUM full-scale products (plus bias) cannot overflow.
    function automatic int acc_width(input int prod_w, input int input_num);
        return prod_w + log2(input_num) + 1 + BIAS_BITS;
    endfunction

endpackage

// File: rtl/weighted_sum_if.sv
// Bus bundle between the weighted_sum block and its neighbours.
//   master: drives start/inputs/weights(/biases), receives addresses/valid/busy
//   slave : the weighted_sum block itself
// Signals:
//   start     - request a new computation
//   inputs    - INPUT_NUM signed inputs, input k at [k*INPUT_WIDTH +: INPUT_WIDTH]
//   weights   - weight(n,k) at [(n*INPUT_NUM+k)*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   biases    - bias n at [n*INPUT_WIDTH +: INPUT_WIDTH] (only with WEIGHTED_SUM_BIAS_EN)
//   addresses - offset-binary LUT address per neuron
//   valid     - one-cycle pulse marking new addresses
//   busy      - computation in progress
interface weighted_sum_if #(
    parameter int NEURON_NUM    = 6,
    parameter int INPUT_NUM     = 8,
    parameter int INPUT_WIDTH   = 8,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int LUT_ADDR_SIZE = 10
);
    logic                                        start;
    logic [INPUT_NUM*INPUT_WIDTH-1:0]            inputs;
    logic [NEURON_NUM*INPUT_NUM*WEIGHT_WIDTH-1:0] weights;
`ifdef WEIGHTED_SUM_BIAS_EN
    logic [NEURON_NUM*INPUT_WIDTH-1:0]           biases;
`endif
    logic [NEURON_NUM*LUT_ADDR_SIZE-1:0]         addresses;
    logic                                        valid;
    logic                                        busy;

    modport master (
`ifdef WEIGHTED_SUM_BIAS_EN
        output biases,
`endif
        output start, inputs, weights,
        input  addresses, valid, busy
    );

    modport slave (
`ifdef WEIGHTED_SUM_BIAS_EN
        input  biases,
`endif
        input  start, inputs, weights,
        output addresses, valid, busy
    );
endinterface

// File: rtl/weighted_sum_sum_to_lut_addr.sv
// sum_to_lut_addr: combinational conversion of one neuron's accumulator to a LUT address.
// Arithmetic shift right (floor), clamp to the signed LUT range, then offset to unsigned.
// Ports:
//   i_acc  - signed accumulator value
//   o_addr - offset-binary LUT address
module sum_to_lut_addr
    import weighted_sum_pkg::*;
#(
    parameter int ACC_W         = 20,
    parameter int SUM_SHIFT     = 4,
    parameter int LUT_ADDR_SIZE = 10
) (
    input  logic signed [ACC_W-1:0]         i_acc,
    output logic        [LUT_ADDR_SIZE-1:0] o_addr
);
    // One bit wider than both operands so clamp bounds and offset fit without wrap.
    localparam int CMP_W = max_int(ACC_W, LUT_ADDR_SIZE) + 1;
    localparam logic signed [CMP_W-1:0] P_MAX    = CMP_W'((1 << (LUT_ADDR_SIZE - 1)) - 1);
    localparam logic signed [CMP_W-1:0] P_MIN    = ~P_MAX;
    localparam logic signed [CMP_W-1:0] P_OFFSET = P_MAX + CMP_W'(1);

    logic signed [ACC_W-1:0] w_shifted;
    logic signed [CMP_W-1:0] w_wide;
    logic signed [CMP_W-1:0] w_clamped;

    assign w_shifted = i_acc >>> SUM_SHIFT;
    assign w_wide    = CMP_W'(w_shifted);

    always_comb begin
        w_clamped = w_wide;
        if (w_wide > P_MAX) begin
            w_clamped = P_MAX;
        end else if (w_wide < P_MIN) begin
            w_clamped = P_MIN;
        end
    end

    assign o_addr = LUT_ADDR_SIZE'(w_clamped + P_OFFSET);
endmodule

// File: rtl/weighted_sum.sv
// weighted_sum: serial-over-inputs, parallel-over-neurons multiply-accumulate producing
// one activation-LUT address per neuron. Start-to-valid latency is INPUT_NUM+2 cycles.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - weighted_sum_if.slave (start, inputs, weights, [biases], addresses, valid, busy)
// Optional feature macro: WEIGHTED_SUM_BIAS_EN (accumulators start from the latched bias).
module weighted_sum
    import weighted_sum_pkg::*;
#(
    parameter int NEURON_NUM    = 6,
    parameter int INPUT_NUM     = 8,
    parameter int INPUT_WIDTH   = 8,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int SUM_SHIFT     = 4,
    parameter int LUT_ADDR_SIZE = 10
) (
    input  logic          clk,
    input  logic          rst,
    weighted_sum_if.slave bus
);
    localparam int PROD_W = INPUT_WIDTH + WEIGHT_WIDTH;
    localparam int ACC_W  = acc_width(PROD_W, INPUT_NUM);
    localparam int K_W    = max_int(1, log2(INPUT_NUM));
    localparam logic [K_W-1:0] K_LAST = K_W'(INPUT_NUM - 1);

    state_t r_state;
    state_t w_next_state;
    logic   w_load;
    logic   w_accum;
    logic   w_convert;

    logic [K_W-1:0]                   r_k;
    logic signed [INPUT_WIDTH-1:0]    r_in  [INPUT_NUM];
    logic signed [WEIGHT_WIDTH-1:0]   r_wt  [NEURON_NUM][INPUT_NUM];
    logic signed [ACC_W-1:0]          r_acc [NEURON_NUM];
    logic [LUT_ADDR_SIZE-1:0]         r_addr[NEURON_NUM];
    logic                             r_valid;

    logic signed [INPUT_WIDTH-1:0]    w_in_bus  [INPUT_NUM];
    logic signed [WEIGHT_WIDTH-1:0]   w_wt_bus  [NEURON_NUM][INPUT_NUM];
    logic signed [PROD_W-1:0]         w_prod    [NEURON_NUM];
    logic signed [ACC_W-1:0]          w_acc_init[NEURON_NUM];
    logic [LUT_ADDR_SIZE-1:0]         w_addr    [NEURON_NUM];

    for (genvar gk = 0; gk < INPUT_NUM; gk++) begin : g_in
        assign w_in_bus[gk] = $signed(bus.inputs[gk*INPUT_WIDTH +: INPUT_WIDTH]);
    end

    for (genvar gn = 0; gn < NEURON_NUM; gn++) begin : g_neuron
        for (genvar gk = 0; gk < INPUT_NUM; gk++) begin : g_wt
            assign w_wt_bus[gn][gk] =
                $signed(bus.weights[(gn*INPUT_NUM+gk)*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
        end
`ifdef WEIGHTED_SUM_BIAS_EN
        assign w_acc_init[gn] = ACC_W'($signed(bus.biases[gn*INPUT_WIDTH +: INPUT_WIDTH]));
`else
        assign w_acc_init[gn] = '0;
`endif
        assign w_prod[gn] = r_in[r_k] * r_wt[gn][r_k];

        sum_to_lut_addr #(
            .ACC_W        (ACC_W),
            .SUM_SHIFT    (SUM_SHIFT),
            .LUT_ADDR_SIZE(LUT_ADDR_SIZE)
        ) u_conv (
            .i_acc (r_acc[gn]),
            .o_addr(w_addr[gn])
        );

        assign bus.addresses[gn*LUT_ADDR_SIZE +: LUT_ADDR_SIZE] = r_addr[gn];
    end

    assign bus.valid = r_valid;
    assign bus.busy  = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_accum      = 1'b0;
        w_convert    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_next_state = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                w_accum = 1'b1;
                if (r_k == K_LAST) begin
                    w_next_state = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                w_convert    = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k <= '0;
        end else if (w_load) begin
            r_k <= '0;
        end else if (w_accum) begin
            r_k <= r_k + 1'b1;
        end
    end

    // Operands are captured once so the source may change during the run.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_in <= w_in_bus;
            r_wt <= w_wt_bus;
        end
    end

    // ---- accumulate / convert stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            for (int n = 0; n < NEURON_NUM; n++) begin
                r_acc[n]  <= '0;
                r_addr[n] <= '0;
            end
        end else begin
            r_valid <= w_convert;
            for (int n = 0; n < NEURON_NUM; n++) begin
                if (w_load) begin
                    r_acc[n] <= w_acc_init[n];
                end else if (w_accum) begin
                    r_acc[n] <= r_acc[n] + ACC_W'(w_prod[n]);
                end
                if (w_convert) begin
                    r_addr[n] <= w_addr[n];
                end
            end
        end
    end
endmodule

// File: tb/tb_weighted_sum.sv
// Self-checking bench for weighted_sum (NEURON_NUM=2, INPUT_NUM=3, 8-bit data,
// SUM_SHIFT=4, LUT_ADDR_SIZE=10). A transaction-level model predicts valid, busy
// and addresses every cycle; directed runs pin literal results and latency.
module tb_weighted_sum;
    localparam int NN = 2;
    localparam int NI = 3;
    localparam int IW = 8;
    localparam int WW = 8;
    localparam int SS = 4;
    localparam int LA = 10;
    localparam int IN_FW = NI * IW;
    localparam int WT_FW = NN * NI * WW;
    localparam int AD_FW = NN * LA;
`ifdef WEIGHTED_SUM_BIAS_EN
    localparam int BI_FW = NN * IW;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    weighted_sum_if #(
        .NEURON_NUM(NN), .INPUT_NUM(NI), .INPUT_WIDTH(IW),
        .WEIGHT_WIDTH(WW), .LUT_ADDR_SIZE(LA)
    ) bus ();

    weighted_sum #(
        .NEURON_NUM(NN), .INPUT_NUM(NI), .INPUT_WIDTH(IW),
        .WEIGHT_WIDTH(WW), .SUM_SHIFT(SS), .LUT_ADDR_SIZE(LA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int in_v[NI];
    int w_v[NN][NI];
`ifdef WEIGHTED_SUM_BIAS_EN
    int b_v[NN];
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: cycles left in the current run, pending and visible results.
    int m_left = 0;
    bit m_valid = 1'b0;
    int m_addr[NN];
    int m_pend[NN];
    logic [AD_FW-1:0] exp_flat;

    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int expected_addr(input int n);
        int acc;
        int s;
        int lim;
        acc = 0;
`ifdef WEIGHTED_SUM_BIAS_EN
        acc = b_v[n];
`endif
        for (int k = 0; k < NI; k++) acc = acc + in_v[k] * w_v[n][k];
        s = floor_div(acc, 1 << SS);
        lim = 1 << (LA - 1);
        if (s > lim - 1) s = lim - 1;
        if (s < -lim) s = -lim;
        return s + lim;
    endfunction

    function automatic logic [AD_FW-1:0] pack_addr(input int a[NN]);
        logic [AD_FW-1:0] f;
        f = '0;
        for (int n = 0; n < NN; n++) f = f | (AD_FW'(a[n] & ((1 << LA) - 1)) << (n * LA));
        return f;
    endfunction

    function automatic int get_addr(input int n);
        return int'((bus.addresses >> (n * LA)) & AD_FW'((1 << LA) - 1));
    endfunction

    task automatic pack_bus();
        logic [IN_FW-1:0] f_in;
        logic [WT_FW-1:0] f_wt;
        f_in = '0;
        f_wt = '0;
        for (int k = 0; k < NI; k++) f_in = f_in | (IN_FW'(in_v[k] & 255) << (k * IW));
        for (int n = 0; n < NN; n++)
            for (int k = 0; k < NI; k++)
                f_wt = f_wt | (WT_FW'(w_v[n][k] & 255) << ((n * NI + k) * WW));
        bus.inputs  = f_in;
        bus.weights = f_wt;
`ifdef WEIGHTED_SUM_BIAS_EN
        begin
            logic [BI_FW-1:0] f_b;
            f_b = '0;
            for (int n = 0; n < NN; n++) f_b = f_b | (BI_FW'(b_v[n] & 255) << (n * IW));
            bus.biases = f_b;
        end
`endif
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_all_weights(input int n, input int v);
        for (int k = 0; k < NI; k++) w_v[n][k] = v;
    endtask

    // Called at a negedge; asserts start for one cycle and waits for valid.
    // Returns the cycle count from the start cycle to the valid cycle (99 on timeout).
    task automatic run_job(output int lat);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (bus.valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (bus.valid !== 1'b1) lat = 99;
    endtask

    // Reference model, advanced on the same edge the DUT samples.
    always @(posedge clk) begin
        if (rst) begin
            m_left  = 0;
            m_valid = 1'b0;
            for (int n = 0; n < NN; n++) m_addr[n] = 0;
        end else begin
            m_valid = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1'b1;
                    m_addr  = m_pend;
                end
            end else if (bus.start === 1'b1) begin
                for (int n = 0; n < NN; n++) m_pend[n] = expected_addr(n);
                m_left = NI + 1;
            end
        end
        exp_flat = pack_addr(m_addr);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (bus.valid !== m_valid || bus.busy !== (m_left > 0) || bus.addresses !== exp_flat) begin
                errors++;
                $display("FAIL cycle t=%0t: valid=%0b busy=%0b addr=%h, expected valid=%0b busy=%0b addr=%h",
                         $time, bus.valid, bus.busy, bus.addresses, m_valid, (m_left > 0), exp_flat);
            end
        end
    end

    initial begin
        int lat;
        int nv;
        bus.start = 1'b0;
        for (int k = 0; k < NI; k++) in_v[k] = 0;
        for (int n = 0; n < NN; n++) set_all_weights(n, 0);
`ifdef WEIGHTED_SUM_BIAS_EN
        for (int n = 0; n < NN; n++) b_v[n] = 0;
`endif
        pack_bus();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_valid", int'(bus.valid), 0);
        check_eq("reset_busy", int'(bus.busy), 0);
        check_eq("reset_addr0", get_addr(0), 0);
        check_eq("reset_addr1", get_addr(1), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Basic sum
        in_v = '{1, 2, 3};
        set_all_weights(0, 16);
        set_all_weights(1, -16);
        pack_bus();
        run_job(lat);
        check_eq("basic_latency", lat, 5);
        check_eq("basic_addr0", get_addr(0), 518);
        check_eq("basic_addr1", get_addr(1), 506);
        check_eq("model_basic0", m_addr[0], 518);
        check_eq("model_basic1", m_addr[1], 506);

        // Saturation, started on the valid cycle of the previous run
        in_v = '{127, 127, 127};
        set_all_weights(0, 127);
        set_all_weights(1, -128);
        pack_bus();
        run_job(lat);
        check_eq("b2b_latency", lat, 5);
        check_eq("sat_addr0", get_addr(0), 1023);
        check_eq("sat_addr1", get_addr(1), 0);
        check_eq("model_sat0", m_addr[0], 1023);
        @(negedge clk);

        // Floor rounding: acc -1 and 15
        in_v = '{1, 0, 0};
        w_v[0] = '{-1, 0, 0};
        w_v[1] = '{15, 0, 0};
        pack_bus();
        run_job(lat);
        check_eq("floor_latency", lat, 5);
        check_eq("floor_addr0", get_addr(0), 511);
        check_eq("floor_addr1", get_addr(1), 512);
        check_eq("model_floor1", m_addr[1], 512);
        @(negedge clk);

        // Stray start during ACCUM must not create a second result
        in_v = '{1, 2, 3};
        set_all_weights(0, 16);
        set_all_weights(1, -16);
        pack_bus();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nv = 0;
        repeat (14) begin
            @(negedge clk);
            if (bus.valid === 1'b1) nv++;
        end
        check_eq("stray_start_valids", nv, 1);

        // Reset during the second ACCUM cycle
        in_v = '{5, 6, 7};
        set_all_weights(0, 3);
        set_all_weights(1, -9);
        pack_bus();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_busy", int'(bus.busy), 0);
        check_eq("midrst_valid", int'(bus.valid), 0);
        check_eq("midrst_addr0", get_addr(0), 0);
        check_eq("midrst_addr1", get_addr(1), 0);
        rst = 1'b0;
        @(negedge clk);
        in_v = '{1, 2, 3};
        set_all_weights(0, 16);
        set_all_weights(1, -16);
        pack_bus();
        run_job(lat);
        check_eq("post_rst_latency", lat, 5);
        check_eq("post_rst_addr0", get_addr(0), 518);
        check_eq("post_rst_addr1", get_addr(1), 506);
        @(negedge clk);

`ifdef WEIGHTED_SUM_BIAS_EN
        b_v = '{32, -32};
        set_all_weights(0, 0);
        set_all_weights(1, 0);
        in_v = '{-100, 50, 7};
        pack_bus();
        run_job(lat);
        check_eq("bias_latency", lat, 5);
        check_eq("bias_addr0", get_addr(0), 514);
        check_eq("bias_addr1", get_addr(1), 510);
        @(negedge clk);
`endif

        // Random traffic: operands change every cycle, starts and resets at random
        repeat (400) begin
            for (int k = 0; k < NI; k++) in_v[k] = int'($urandom_range(0, 255)) - 128;
            for (int n = 0; n < NN; n++)
                for (int k = 0; k < NI; k++) w_v[n][k] = int'($urandom_range(0, 255)) - 128;
`ifdef WEIGHTED_SUM_BIAS_EN
            for (int n = 0; n < NN; n++) b_v[n] = int'($urandom_range(0, 255)) - 128;
`endif
            pack_bus();
            bus.start = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 60) == 0);
            @(negedge clk);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
